sdram_tester: RTL and testbench

Self-running memory test engine sitting directly upstream of the Apple II SDRAM controller. It runs on the controller's fast clock and aligns itself to the 14 MHz `clkref`. Once per reference cycle it issues one byte access through the controller's `addr`/`din`/`we`/`aux` inputs. It checks read data from the controller's 16-bit `dout`, and reports pass count, error count and the first failing access.

---
 rtl/sdram_tester.sv | 246 ++++++++++++++++++++++++
 tb/tb_sdram_tester.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_tester.sv
// sdram_tester: self-running write/read pattern test engine upstream of the Apple II SDRAM controller.
// Build macro SDRAM_TESTER_STOP_ON_ERROR_EN adds a HALT state entered on the first mismatch.
//
// state | meaning
// IDLE  | not testing, access outputs parked at index 0
// INIT  | counting reference cycles while the controller initialises
// WRITE | one pattern write per reference cycle
// READ  | one pattern read per reference cycle, checked RD_SAMPLE clk later
// HALT  | frozen after first mismatch (macro builds only)
module sdram_tester #(
    parameter int ADDR_BITS   = 21,
    parameter int INIT_CYCLES = 40,
    parameter int RD_SAMPLE   = 6
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 clkref,
    input  logic                 run,
    input  logic [15:0]          dout,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 aux,
    output logic [7:0]           din,
    output logic                 we,
    output logic                 busy,
    output logic [1:0]           pattern,
    output logic [7:0]           pass_cnt,
    output logic                 error,
    output logic [15:0]          err_cnt,
    output logic [ADDR_BITS:0]   err_addr,
    output logic [7:0]           err_exp,
    output logic [7:0]           err_got
);

    localparam int IW  = ADDR_BITS + 1;
    localparam int ICW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam int SCW = (RD_SAMPLE < 2) ? 1 : $clog2(RD_SAMPLE);
    localparam logic [IW-1:0] IDX_MAX = {IW{1'b1}};

`ifdef SDRAM_TESTER_STOP_ON_ERROR_EN
    typedef enum logic [2:0] {IDLE, INIT, WRITE, READ, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, INIT, WRITE, READ} state_t;
`endif

    state_t          state_q, state_d;
    logic            clkref_q;
    logic            stb;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      pat_q, pat_d;
    logic [7:0]      din_q, din_d;
    logic            we_q, we_d;
    logic [7:0]      exp_q, exp_d;
    logic [ICW-1:0]  icnt_q, icnt_d;
    logic [7:0]      pass_q, pass_d;
    logic            rd_start;

    logic [SCW-1:0]  smp_cnt_q;
    logic            smp_pend_q;
    logic            chk_q;
    logic [7:0]      got_q, chk_exp_q;
    logic [IW-1:0]   chk_idx_q;
    logic            error_q;
    logic [15:0]     err_cnt_q;
    logic [IW-1:0]   err_addr_q;
    logic [7:0]      err_exp_q, err_got_q;

    function automatic logic [7:0] pat_byte(input logic [1:0] p, input logic [IW-1:0] i);
        logic [15:0] iw;
        iw = 16'(i);
        case (p)
            2'd0:    pat_byte = 8'h55;
            2'd1:    pat_byte = 8'hAA;
            2'd2:    pat_byte = iw[7:0] ^ iw[15:8];
            default: pat_byte = ~(iw[7:0] ^ iw[15:8]);
        endcase
    endfunction

    assign stb = clkref & ~clkref_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        din_d    = din_q;
        we_d     = we_q;
        exp_d    = exp_q;
        icnt_d   = icnt_q;
        pass_d   = pass_q;
        rd_start = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                pat_d = '0;
                we_d  = 1'b0;
                if (run) begin
                    state_d = INIT;
                    icnt_d  = ICW'(INIT_CYCLES);
                end
            end
            INIT: if (stb) begin
                if (!run) begin
                    state_d = IDLE;
                end else if (icnt_q == '0) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    we_d    = 1'b1;
                    din_d   = pat_byte(pat_q, '0);
                end else begin
                    icnt_d = icnt_q - 1'b1;
                end
            end
            WRITE: if (stb) begin
`ifdef SDRAM_TESTER_STOP_ON_ERROR_EN
                if (error_q) begin
                    state_d = HALT;
                    we_d    = 1'b0;
                end else
`endif
                if (!run) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    pat_d   = '0;
                    we_d    = 1'b0;
                end else if (idx_q == IDX_MAX) begin
                    state_d  = READ;
                    idx_d    = '0;
                    we_d     = 1'b0;
                    exp_d    = pat_byte(pat_q, '0);
                    rd_start = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    din_d = pat_byte(pat_q, idx_q + 1'b1);
                end
            end
            READ: if (stb) begin
`ifdef SDRAM_TESTER_STOP_ON_ERROR_EN
                if (error_q) begin
                    state_d = HALT;
                    we_d    = 1'b0;
                end else
`endif
                if (!run) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    pat_d   = '0;
                    we_d    = 1'b0;
                end else if (idx_q == IDX_MAX) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    pat_d   = pat_q + 2'd1;
                    we_d    = 1'b1;
                    din_d   = pat_byte(pat_q + 2'd1, '0);
                    if (pat_q == 2'd3) pass_d = pass_q + 8'd1;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    exp_d    = pat_byte(pat_q, idx_q + 1'b1);
                    rd_start = 1'b1;
                end
            end
`ifdef SDRAM_TESTER_STOP_ON_ERROR_EN
            HALT: we_d = 1'b0;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q  <= IDLE;
            clkref_q <= 1'b0;
            idx_q    <= '0;
            pat_q    <= '0;
            din_q    <= '0;
            we_q     <= 1'b0;
            exp_q    <= '0;
            icnt_q   <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            clkref_q <= clkref;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            din_q    <= din_d;
            we_q     <= we_d;
            exp_q    <= exp_d;
            icnt_q   <= icnt_d;
            pass_q   <= pass_d;
        end
    end

    // Sample runs independently of the FSM so a read in flight still checks after run drops.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            smp_cnt_q  <= '0;
            smp_pend_q <= 1'b0;
            chk_q      <= 1'b0;
            got_q      <= '0;
            chk_exp_q  <= '0;
            chk_idx_q  <= '0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            chk_q <= 1'b0;
            if (rd_start) begin
                smp_pend_q <= 1'b1;
                smp_cnt_q  <= SCW'(RD_SAMPLE - 1);
            end else if (smp_pend_q) begin
                if (smp_cnt_q == '0) begin
                    smp_pend_q <= 1'b0;
                    chk_q      <= 1'b1;
                    got_q      <= idx_q[0] ? dout[15:8] : dout[7:0];
                    chk_exp_q  <= exp_q;
                    chk_idx_q  <= idx_q;
                end else begin
                    smp_cnt_q <= smp_cnt_q - 1'b1;
                end
            end
            if (chk_q && (got_q != chk_exp_q)) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                if (!error_q) begin
                    error_q    <= 1'b1;
                    err_addr_q <= chk_idx_q;
                    err_exp_q  <= chk_exp_q;
                    err_got_q  <= got_q;
                end
            end
        end
    end

    assign addr     = idx_q[IW-1:1];
    assign aux      = idx_q[0];
    assign din      = din_q;
    assign we       = we_q;
    assign busy     = (state_q == WRITE) || (state_q == READ);
    assign pattern  = pat_q;
    assign pass_cnt = pass_q;
    assign error    = error_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;

endmodule

// File: tb/tb_sdram_tester.sv
// Bench for sdram_tester: ideal byte-lane memory with optional read faults, checked per access
// against a position-based reference model of the write/read pattern sequence.
module tb_sdram_tester;

    localparam int AB    = 4;
    localparam int INITC = 40;
    localparam int NIDX  = 1 << (AB + 1);
`ifdef SDRAM_TESTER_STOP_ON_ERROR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk;
    logic          init_n;
    logic          clkref;
    logic          run;
    logic [15:0]   dout;
    logic [AB-1:0] addr;
    logic          aux;
    logic [7:0]    din;
    logic          we;
    logic          busy;
    logic [1:0]    pattern;
    logic [7:0]    pass_cnt;
    logic          error;
    logic [15:0]   err_cnt;
    logic [AB:0]   err_addr;
    logic [7:0]    err_exp;
    logic [7:0]    err_got;

    sdram_tester #(.ADDR_BITS(AB), .INIT_CYCLES(INITC), .RD_SAMPLE(6)) dut (
        .clk(clk), .init_n(init_n), .clkref(clkref), .run(run), .dout(dout),
        .addr(addr), .aux(aux), .din(din), .we(we), .busy(busy), .pattern(pattern),
        .pass_cnt(pass_cnt), .error(error), .err_cnt(err_cnt), .err_addr(err_addr),
        .err_exp(err_exp), .err_got(err_got)
    );

    logic [2:0] ph = 3'd0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) ph <= ph + 3'd1;
    assign clkref = (ph < 3'd4);

    // Controller model: byte-lane writes, 16-bit read word with an optional fault on the read path.
    int         f_mode;
    logic [3:0] f_bit;
    logic       f_val;
    logic [15:0] mem [0:(1<<AB)-1];
    logic [15:0] w_rd;
    always @(posedge clk) begin
        if (we) begin
            if (aux) mem[addr][15:8] <= din;
            else     mem[addr][7:0]  <= din;
        end
    end
    always_comb begin
        w_rd = mem[addr];
        if (f_mode == 1) w_rd[f_bit] = f_val;
        else if (f_mode == 2 && addr == '0) w_rd = 16'hAA55;
    end
    assign dout = w_rd;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input int i);
        logic [15:0] v;
        v = i[15:0];
        case (p)
            0:       pat = 8'h55;
            1:       pat = 8'hAA;
            2:       pat = v[7:0] ^ v[15:8];
            default: pat = ~(v[7:0] ^ v[15:8]);
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 init, 2 testing at sequence position m_k, 3 halted.
    int         m_phase, m_init_left, m_k, m_pass, m_last_addr;
    int         m_err_cnt, m_err_addr;
    logic       m_error;
    logic [7:0] m_err_exp, m_err_got;

    task automatic set_run(input logic v);
        run = v;
        if (v && m_phase == 0) begin
            m_phase     = 1;
            m_init_left = INITC;
        end
    endtask

    task automatic model_read(input int p, input int i);
        logic [15:0] w;
        logic [7:0]  got, e;
        w = {pat(p, i | 1), pat(p, i & ~1)};
        if (f_mode == 1) w[f_bit] = f_val;
        else if (f_mode == 2 && (i >> 1) == 0) w = 16'hAA55;
        got = (i & 1) ? w[15:8] : w[7:0];
        e   = pat(p, i);
        if (got != e) begin
            if (m_err_cnt < 65535) m_err_cnt++;
            if (!m_error) begin
                m_error    = 1'b1;
                m_err_addr = i;
                m_err_exp  = e;
                m_err_got  = got;
            end
        end
    endtask

    task automatic step();
        int   n, p, j, i;
        logic wr;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ph != 3'd1 && n < 16);
        check("stb_timeout", 32'(n < 16), 32'd1);
        check("err_cnt", err_cnt, m_err_cnt);
        check("error", error, m_error);
        if (m_error) begin
            check("err_addr", err_addr, m_err_addr);
            check("err_exp", err_exp, m_err_exp);
            check("err_got", err_got, m_err_got);
        end
        case (m_phase)
            1: begin
                if (!run) m_phase = 0;
                else if (m_init_left == 0) begin
                    m_phase = 2;
                    m_k     = 0;
                end else m_init_left--;
            end
            2: begin
                if (STOP && m_error) m_phase = 3;
                else if (!run) m_phase = 0;
                else begin
                    m_k++;
                    if (m_k % (8 * NIDX) == 0) m_pass = (m_pass + 1) % 256;
                end
            end
            default: ;
        endcase
        check("pass_cnt", pass_cnt, m_pass);
        if (m_phase == 2) begin
            p  = (m_k / (2 * NIDX)) % 4;
            j  = m_k % (2 * NIDX);
            wr = (j < NIDX);
            i  = j % NIDX;
            check("we", we, wr);
            check("busy", busy, 1);
            check("pattern", pattern, p);
            check("addr", addr, i >> 1);
            check("aux", aux, i & 1);
            if (wr) check("din", din, pat(p, i));
            else model_read(p, i);
            m_last_addr = i >> 1;
        end else begin
            check("we_off", we, 0);
            check("busy_off", busy, 0);
            if (m_phase == 3) check("addr_frozen", addr, m_last_addr);
            else begin
                check("addr_idle", addr, 0);
                check("pattern_idle", pattern, 0);
            end
        end
    endtask

    task automatic do_reset();
        int n;
        #2 init_n = 1'b0;
        run = 1'b0;
        #1;
        check("rst_addr", addr, 0);
        check("rst_aux", aux, 0);
        check("rst_din", din, 0);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_pattern", pattern, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_error", error, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_exp", err_exp, 0);
        check("rst_err_got", err_got, 0);
        m_phase = 0; m_k = 0; m_pass = 0; m_last_addr = 0;
        m_err_cnt = 0; m_error = 1'b0; m_err_addr = 0; m_err_exp = '0; m_err_got = '0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ph != 3'd5 && n < 16);
        init_n = 1'b1;
    endtask

    initial begin
        int r;
        init_n = 1'b1;
        run    = 1'b0;
        f_mode = 0;
        f_bit  = '0;
        f_val  = 1'b0;

        // Clean memory: 40 idle INIT strobes, first write at strobe 41, then one full pass.
        do_reset();
        set_run(1'b1);
        repeat (INITC) step();
        step();
        check("first_we", we, 1);
        check("first_din", din, 8'h55);
        check("first_busy", busy, 1);
        repeat (8 * NIDX) step();
        check("pass1_cnt", pass_cnt, 1);
        check("pass1_err_cnt", err_cnt, 0);

        // Random stuck read bit; reset lands asynchronously in the middle of a pass.
        repeat (5) step();
        f_mode = 1;
        f_bit  = 4'($urandom_range(0, 15));
        f_val  = 1'($urandom_range(0, 1));
        do_reset();
        set_run(1'b1);
        repeat (INITC + 8 * NIDX + 1) step();

        // Word 16'hAA55 at addr 0: only the high lane of index 1 fails; drop run mid-READ and restart.
        f_mode = 2;
        do_reset();
        set_run(1'b1);
        repeat (INITC + 1 + NIDX) step();
        r = $urandom_range(2, 20);
        repeat (r) step();
        set_run(1'b0);
        step();
        step();
        check("lane_err_addr", err_addr, 1);
        check("lane_err_exp", err_exp, 8'h55);
        check("lane_err_got", err_got, 8'hAA);
        check("lane_err_cnt", err_cnt, 1);
        set_run(1'b1);
        repeat (INITC + 3) step();
`ifndef SDRAM_TESTER_STOP_ON_ERROR_EN
        check("restart_busy", busy, 1);
        check("restart_pattern", pattern, 0);
`endif
        check("restart_error_kept", error, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
